// File: rtl/ether_agent_pkg.sv
// Shared encodings for the UDP host agent: TX/RX handshake states and
// the one-hot size classes reported for received packets.
package ether_agent_pkg;

   typedef enum logic [1:0] {
      T_IDLE = 2'd0,
      T_PEND = 2'd1,
      T_REL  = 2'd2
   } tx_state_t;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_HOLD = 2'd1,
      R_REL  = 2'd2,
      R_WAIT = 2'd3
   } rx_state_t;

   localparam logic [2:0] SIZE_CLASS_EMPTY = 3'b000;
   localparam logic [2:0] SIZE_CLASS_SMALL = 3'b001;
   localparam logic [2:0] SIZE_CLASS_MID   = 3'b010;
   localparam logic [2:0] SIZE_CLASS_LARGE = 3'b100;

   function automatic logic [2:0] size_class_of(input logic [15:0]   size,
                                                input int unsigned   bin0_max,
                                                input int unsigned   bin1_max);
      logic [2:0] cls;
      if (size == 16'd0)              cls = SIZE_CLASS_EMPTY;
      else if (32'(size) <= bin0_max) cls = SIZE_CLASS_SMALL;
      else if (32'(size) <= bin1_max) cls = SIZE_CLASS_MID;
      else                            cls = SIZE_CLASS_LARGE;
      return cls;
   endfunction

endpackage

// File: rtl/udp_agent_msg_table.sv
// Outgoing message store: one write port, one registered read port.
// A same-cycle write and read of one word returns the previous contents.
module udp_agent_msg_table
   import ether_agent_pkg::*;
#(
   parameter int unsigned DEPTH = 32,
   parameter int unsigned AW    = 5
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [31:0]   i_wdata,
   input  logic          i_rd_en,
   input  logic [AW-1:0] i_raddr,
   output logic [31:0]   o_rdata
);

   logic [31:0] r_mem [DEPTH];
   logic [31:0] r_rdata;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_rdata <= '0;
      end else begin
         if (i_we) r_mem[i_waddr] <= i_wdata;
         r_rdata <= i_rd_en ? r_mem[i_raddr] : 32'd0;
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/udp_host_agent.sv
// CPU-side stand-in for the UDP stack buffer handshakes: periodic round-robin
// message release on TX, timed buffer hand-back and size capture on RX.
module udp_host_agent
   import ether_agent_pkg::*;
#(
   parameter int unsigned TXBUF_AWIDTH = 6,
   parameter int unsigned RXBUF_AWIDTH = 9,
   parameter int unsigned NUM_SLOTS    = 4,
   parameter int unsigned MSG_WORDS    = 8,
   parameter int unsigned TX_PERIOD    = 125000000,
   parameter int unsigned RX_HOLD      = 0,
   parameter int unsigned RX_SIZE_WORD = 1,
   parameter int unsigned BIN0_MAX     = 10,
   parameter int unsigned BIN1_MAX     = 20,
   localparam int unsigned CFG_AW = (NUM_SLOTS * MSG_WORDS > 1) ? $clog2(NUM_SLOTS * MSG_WORDS) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    tx_en,
   input  logic                    cfg_we,
   input  logic [CFG_AW-1:0]       cfg_addr,
   input  logic [31:0]             cfg_wdata,
   input  logic                    udp_txbuf_cpu_grant,
   output logic                    udp_txbuf_cpu_rel,
   input  logic [TXBUF_AWIDTH-1:0] udp_txbuf_addr,
   output logic [31:0]             udp_txbuf_rdata,
   input  logic                    udp_rxbuf_cpu_grant,
   output logic                    udp_rxbuf_cpu_rel,
   input  logic [RXBUF_AWIDTH-1:0] udp_rxbuf_addr,
   input  logic                    udp_rxbuf_we,
   input  logic [31:0]             udp_rxbuf_wdata,
   output logic [15:0]             last_rx_size,
   output logic [2:0]              size_class,
   output logic [15:0]             tx_count,
   output logic [15:0]             tx_drop_count,
   output logic [15:0]             rx_count
);

   localparam int unsigned SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
   localparam int unsigned CNT_W  = $clog2(TX_PERIOD);
   localparam int unsigned HOLD_W = (RX_HOLD > 0) ? $clog2(RX_HOLD + 1) : 1;

   tx_state_t          r_tx_state, w_tx_next;
   rx_state_t          r_rx_state, w_rx_next;
   logic [CNT_W-1:0]   r_period_cnt;
   logic [SLOT_W-1:0]  r_slot;
   logic [HOLD_W-1:0]  r_hold_cnt, w_hold_next;
   logic               r_tx_rel, r_rx_rel;
   logic [15:0]        r_tx_count, r_tx_drop, r_rx_count, r_last_rx_size;
   logic [2:0]         r_size_class;
   logic               w_tick, w_drop_inc, w_rd_en;
   logic [CFG_AW-1:0]  w_rd_idx;
   logic               w_unused_ok;

   assign w_tick      = tx_en && (r_period_cnt == CNT_W'(TX_PERIOD - 1));
   assign w_rd_en     = (32'(udp_txbuf_addr) < MSG_WORDS);
   assign w_rd_idx    = CFG_AW'(32'(r_slot) * MSG_WORDS + 32'(udp_txbuf_addr));
   assign w_unused_ok = ^udp_rxbuf_wdata[15:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                   r_period_cnt <= '0;
      else if (!tx_en || w_tick) r_period_cnt <= '0;
      else                       r_period_cnt <= r_period_cnt + CNT_W'(1);
   end

   // A tick that finds a release still pending has nowhere to queue, so it is counted as lost.
   always_comb begin
      w_tx_next  = r_tx_state;
      w_drop_inc = 1'b0;
      case (r_tx_state)
         T_IDLE:  if (w_tick) w_tx_next = udp_txbuf_cpu_grant ? T_REL : T_PEND;
         T_PEND: begin
            w_drop_inc = w_tick;
            if (udp_txbuf_cpu_grant) w_tx_next = T_REL;
         end
         T_REL:   w_tx_next = w_tick ? T_PEND : T_IDLE;
         default: w_tx_next = T_IDLE;
      endcase
      if (!tx_en && (r_tx_state != T_REL)) w_tx_next = T_IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tx_state <= T_IDLE;
         r_tx_rel   <= 1'b0;
         r_slot     <= '0;
         r_tx_count <= '0;
         r_tx_drop  <= '0;
      end else begin
         r_tx_state <= w_tx_next;
         r_tx_rel   <= (w_tx_next == T_REL);
         if (r_tx_state == T_REL) begin
            r_slot     <= (r_slot == SLOT_W'(NUM_SLOTS - 1)) ? '0 : r_slot + SLOT_W'(1);
            r_tx_count <= r_tx_count + 16'd1;
         end
         if (w_drop_inc && (r_tx_drop != 16'hFFFF)) r_tx_drop <= r_tx_drop + 16'd1;
      end
   end

   udp_agent_msg_table #(
      .DEPTH (NUM_SLOTS * MSG_WORDS),
      .AW    (CFG_AW)
   ) u_msg_table (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_we    (cfg_we),
      .i_waddr (cfg_addr),
      .i_wdata (cfg_wdata),
      .i_rd_en (w_rd_en),
      .i_raddr (w_rd_idx),
      .o_rdata (udp_txbuf_rdata)
   );

   // Hold counter holds the grant cycles still owed before the buffer is handed back.
   always_comb begin
      w_rx_next   = r_rx_state;
      w_hold_next = r_hold_cnt;
      case (r_rx_state)
         R_IDLE: if (udp_rxbuf_cpu_grant) begin
            w_rx_next   = (RX_HOLD == 0) ? R_REL : R_HOLD;
            w_hold_next = HOLD_W'(RX_HOLD);
         end
         R_HOLD: begin
            if (!udp_rxbuf_cpu_grant)             w_rx_next   = R_IDLE;
            else if (r_hold_cnt <= HOLD_W'(1))    w_rx_next   = R_REL;
            else                                  w_hold_next = r_hold_cnt - HOLD_W'(1);
         end
         R_REL:   w_rx_next = R_WAIT;
         R_WAIT:  if (!udp_rxbuf_cpu_grant) w_rx_next = R_IDLE;
         default: w_rx_next = R_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rx_state     <= R_IDLE;
         r_hold_cnt     <= '0;
         r_rx_rel       <= 1'b0;
         r_rx_count     <= '0;
         r_last_rx_size <= '0;
         r_size_class   <= SIZE_CLASS_EMPTY;
      end else begin
         r_rx_state <= w_rx_next;
         r_hold_cnt <= w_hold_next;
         r_rx_rel   <= (w_rx_next == R_REL);
         if (r_rx_state == R_REL) r_rx_count <= r_rx_count + 16'd1;
         if (udp_rxbuf_we && (udp_rxbuf_addr == RXBUF_AWIDTH'(RX_SIZE_WORD)))
            r_last_rx_size <= udp_rxbuf_wdata[31:16];
         r_size_class <= size_class_of(r_last_rx_size, BIN0_MAX, BIN1_MAX);
      end
   end

   assign udp_txbuf_cpu_rel = r_tx_rel;
   assign udp_rxbuf_cpu_rel = r_rx_rel;
   assign tx_count          = r_tx_count;
   assign tx_drop_count     = r_tx_drop;
   assign rx_count          = r_rx_count;
   assign last_rx_size      = r_last_rx_size;
   assign size_class        = r_size_class;

endmodule

// File: tb/tb_udp_host_agent.sv
// Self-checking bench for udp_host_agent: directed sequences, a table of rx size
// vectors, and randomized traffic compared against a behavioural reference model.
module tb_udp_host_agent;

   localparam int unsigned TXBUF_AWIDTH = 6;
   localparam int unsigned RXBUF_AWIDTH = 9;
   localparam int unsigned NUM_SLOTS    = 4;
   localparam int unsigned MSG_WORDS    = 8;
   localparam int unsigned TX_PERIOD    = 16;
   localparam int unsigned RX_HOLD      = 3;
   localparam int unsigned RX_SIZE_WORD = 1;
   localparam int unsigned BIN0_MAX     = 10;
   localparam int unsigned BIN1_MAX     = 20;
   localparam int unsigned DEPTH        = NUM_SLOTS * MSG_WORDS;

   logic                    clk = 1'b0;
   logic                    rst, tx_en, cfg_we, tx_grant, rx_grant, rx_we;
   logic [4:0]              cfg_addr;
   logic [31:0]             cfg_wdata, rx_wdata;
   logic [TXBUF_AWIDTH-1:0] tx_addr;
   logic [RXBUF_AWIDTH-1:0] rx_addr;
   logic                    tx_rel, rx_rel;
   logic [31:0]             tx_rdata;
   logic [15:0]             last_size, tx_cnt, drop_cnt, rx_cnt;
   logic [2:0]              size_cls;

   udp_host_agent #(
      .TXBUF_AWIDTH (TXBUF_AWIDTH), .RXBUF_AWIDTH (RXBUF_AWIDTH),
      .NUM_SLOTS    (NUM_SLOTS),    .MSG_WORDS    (MSG_WORDS),
      .TX_PERIOD    (TX_PERIOD),    .RX_HOLD      (RX_HOLD),
      .RX_SIZE_WORD (RX_SIZE_WORD), .BIN0_MAX     (BIN0_MAX),
      .BIN1_MAX     (BIN1_MAX)
   ) dut (
      .clk                 (clk),
      .rst                 (rst),
      .tx_en               (tx_en),
      .cfg_we              (cfg_we),
      .cfg_addr            (cfg_addr),
      .cfg_wdata           (cfg_wdata),
      .udp_txbuf_cpu_grant (tx_grant),
      .udp_txbuf_cpu_rel   (tx_rel),
      .udp_txbuf_addr      (tx_addr),
      .udp_txbuf_rdata     (tx_rdata),
      .udp_rxbuf_cpu_grant (rx_grant),
      .udp_rxbuf_cpu_rel   (rx_rel),
      .udp_rxbuf_addr      (rx_addr),
      .udp_rxbuf_we        (rx_we),
      .udp_rxbuf_wdata     (rx_wdata),
      .last_rx_size        (last_size),
      .size_class          (size_cls),
      .tx_count            (tx_cnt),
      .tx_drop_count       (drop_cnt),
      .rx_count            (rx_cnt)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state
   logic [31:0] m_tbl [DEPTH];
   int unsigned m_phase, m_slot, m_streak;
   logic        m_pending, m_tx_rel, m_rx_rel, m_rx_wait;
   logic [31:0] m_rdata;
   logic [15:0] m_tx_count, m_drop, m_rx_count, m_size;
   logic [2:0]  m_class;

   typedef struct {
      logic [8:0]  addr;
      logic [31:0] wdata;
      logic [15:0] size;
      logic [2:0]  cls;
   } rx_vec_t;
   rx_vec_t vecs [10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [2:0] ref_class(input logic [15:0] s);
      if (s == 16'd0)      return 3'b000;
      if (s <= BIN0_MAX)   return 3'b001;
      if (s <= BIN1_MAX)   return 3'b010;
      return 3'b100;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < int'(DEPTH); i++) m_tbl[i] = '0;
      m_phase = 0; m_slot = 0; m_streak = 0;
      m_pending = 0; m_tx_rel = 0; m_rx_rel = 0; m_rx_wait = 0;
      m_rdata = '0; m_tx_count = '0; m_drop = '0; m_rx_count = '0;
      m_size = '0; m_class = '0;
   endtask

   // Advance the model across one clock edge using the inputs of the closing cycle.
   task automatic model_edge();
      logic tick;
      if (rst) begin
         model_reset();
         return;
      end
      m_rdata = (int'(tx_addr) < int'(MSG_WORDS)) ? m_tbl[m_slot * MSG_WORDS + int'(tx_addr)] : 32'd0;
      if (cfg_we) m_tbl[cfg_addr] = cfg_wdata;

      tick = tx_en && (m_phase == TX_PERIOD - 1);
      if (m_tx_rel) begin
         m_slot     = (m_slot + 1) % NUM_SLOTS;
         m_tx_count = m_tx_count + 16'd1;
         m_tx_rel   = 0;
         m_pending  = tick;
      end else if (!tx_en) begin
         m_pending = 0;
      end else if (m_pending) begin
         if (tick && m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
         if (tx_grant) begin m_pending = 0; m_tx_rel = 1; end
      end else if (tick) begin
         if (tx_grant) m_tx_rel = 1; else m_pending = 1;
      end
      m_phase = tx_en ? (m_phase + 1) % TX_PERIOD : 0;

      // Rx buffer goes back once grant has been held RX_HOLD+1 consecutive cycles.
      if (m_rx_rel) begin
         m_rx_rel = 0; m_rx_count = m_rx_count + 16'd1; m_rx_wait = 1; m_streak = 0;
      end else if (m_rx_wait) begin
         if (!rx_grant) m_rx_wait = 0;
      end else begin
         m_streak = rx_grant ? m_streak + 1 : 0;
         if (m_streak == RX_HOLD + 1) begin m_rx_rel = 1; m_streak = 0; end
      end

      m_class = ref_class(m_size);
      if (rx_we && int'(rx_addr) == int'(RX_SIZE_WORD)) m_size = rx_wdata[31:16];
   endtask

   task automatic compare_all();
      check("tx_rel",        32'(tx_rel),    32'(m_tx_rel));
      check("txbuf_rdata",   tx_rdata,       m_rdata);
      check("rx_rel",        32'(rx_rel),    32'(m_rx_rel));
      check("last_rx_size",  32'(last_size), 32'(m_size));
      check("size_class",    32'(size_cls),  32'(m_class));
      check("tx_count",      32'(tx_cnt),    32'(m_tx_count));
      check("tx_drop_count", 32'(drop_cnt),  32'(m_drop));
      check("rx_count",      32'(rx_cnt),    32'(m_rx_count));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic idle_inputs();
      tx_en = 0; cfg_we = 0; cfg_addr = '0; cfg_wdata = '0; tx_grant = 0; tx_addr = '0;
      rx_grant = 0; rx_we = 0; rx_addr = '0; rx_wdata = '0;
   endtask

   task automatic do_reset();
      rst = 1;
      idle_inputs();
      step(); step();
      rst = 0;
   endtask

   task automatic cfg_write(input logic [4:0] a, input logic [31:0] d);
      cfg_we = 1; cfg_addr = a; cfg_wdata = d;
      step();
      cfg_we = 0;
   endtask

   initial begin
      int first_rel, last_rel, n_rel;
      logic [2:0] prev_cls;
      logic [31:0] rel_words [$];

      vecs[0] = '{9'd1, 32'h000F_0000, 16'd15,    3'b010};
      vecs[1] = '{9'd1, 32'h0005_0000, 16'd5,     3'b001};
      vecs[2] = '{9'd1, 32'h0020_0000, 16'd32,    3'b100};
      vecs[3] = '{9'd1, 32'h0000_1234, 16'd0,     3'b000};
      vecs[4] = '{9'd1, 32'h000A_0000, 16'd10,    3'b001};
      vecs[5] = '{9'd1, 32'h000B_0000, 16'd11,    3'b010};
      vecs[6] = '{9'd1, 32'h0014_0000, 16'd20,    3'b010};
      vecs[7] = '{9'd1, 32'h0015_0000, 16'd21,    3'b100};
      vecs[8] = '{9'd2, 32'h0003_0000, 16'd21,    3'b100};
      vecs[9] = '{9'd1, 32'h0001_FFFF, 16'd1,     3'b001};

      rst = 1;
      idle_inputs();
      model_reset();
      #1;
      check("reset_tx_rel",   32'(tx_rel), 32'd0);
      check("reset_rdata",    tx_rdata,    32'd0);
      check("reset_tx_count", 32'(tx_cnt), 32'd0);
      do_reset();

      // Periodic release with grant held high
      cfg_write(5'd0, 32'h0a01a8c0);
      tx_en = 1; tx_grant = 1; tx_addr = '0;
      first_rel = -1; last_rel = -1; n_rel = 0;
      for (int k = 1; k <= 50; k++) begin
         step();
         if (k == 1) check("rdata_latency", tx_rdata, 32'h0a01a8c0);
         if (tx_rel) begin
            n_rel++;
            if (first_rel < 0) begin
               first_rel = k;
               check("released_word", tx_rdata, 32'h0a01a8c0);
            end
            last_rel = k;
         end
      end
      check("first_rel_cycle", 32'(first_rel), 32'd16);
      check("last_rel_cycle",  32'(last_rel),  32'd48);
      check("rel_pulses",      32'(n_rel),     32'd3);
      check("tx_count_3",      32'(tx_cnt),    32'd3);

      // Grant low across three ticks, then raised
      do_reset();
      tx_en = 1; tx_grant = 0; n_rel = 0;
      for (int k = 0; k < 50; k++) begin step(); if (tx_rel) n_rel++; end
      tx_grant = 1;
      for (int k = 0; k < 5; k++) begin step(); if (tx_rel) n_rel++; end
      check("late_grant_pulses", 32'(n_rel),    32'd1);
      check("drop_count_2",      32'(drop_cnt), 32'd2);
      check("tx_count_1",        32'(tx_cnt),   32'd1);

      // Round-robin slot order
      do_reset();
      for (int s = 0; s < int'(NUM_SLOTS); s++) cfg_write(5'(s * MSG_WORDS), 32'(s));
      cfg_write(5'd9, 32'h1234_5678);
      tx_en = 1; tx_grant = 1; tx_addr = '0;
      rel_words.delete();
      for (int k = 0; k < 82; k++) begin step(); if (tx_rel) rel_words.push_back(tx_rdata); end
      check("rr_pulses", 32'(rel_words.size()), 32'd5);
      for (int i = 0; i < 5 && i < rel_words.size(); i++)
         check("rr_word0", rel_words[i], 32'(i % NUM_SLOTS));
      tx_addr = 6'(MSG_WORDS);
      step();
      check("addr_out_of_range", tx_rdata, 32'd0);

      // Rx size capture and classification
      do_reset();
      prev_cls = 3'b000;
      for (int i = 0; i < 10; i++) begin
         rx_we = 1; rx_addr = vecs[i].addr; rx_wdata = vecs[i].wdata;
         step();
         rx_we = 0;
         check("rx_size",      32'(last_size), 32'(vecs[i].size));
         check("rx_class_lag", 32'(size_cls),  32'(prev_cls));
         step();
         check("rx_class",     32'(size_cls),  32'(vecs[i].cls));
         prev_cls = vecs[i].cls;
      end

      // Rx hold: long grant, then short grant
      do_reset();
      rx_grant = 1; first_rel = -1; n_rel = 0;
      for (int k = 1; k <= 10; k++) begin
         step();
         if (rx_rel) begin n_rel++; if (first_rel < 0) first_rel = k; end
      end
      check("rx_rel_cycle",  32'(first_rel), 32'd4);
      check("rx_rel_pulses", 32'(n_rel),     32'd1);
      check("rx_count_1",    32'(rx_cnt),    32'd1);
      rx_grant = 0; repeat (3) step();
      rx_grant = 1; n_rel = 0;
      for (int k = 0; k < 2; k++) begin step(); if (rx_rel) n_rel++; end
      rx_grant = 0;
      for (int k = 0; k < 10; k++) begin step(); if (rx_rel) n_rel++; end
      check("rx_abort_pulses", 32'(n_rel),  32'd0);
      check("rx_count_still1", 32'(rx_cnt), 32'd1);

      // Asynchronous reset while a release is pending
      do_reset();
      cfg_write(5'd0, 32'hDEAD_BEEF);
      rx_we = 1; rx_addr = 9'd1; rx_wdata = 32'h0007_0000; step(); rx_we = 0;
      tx_en = 1; tx_grant = 0; tx_addr = '0;
      repeat (40) step();
      check("pend_drop_1", 32'(drop_cnt), 32'd1);
      #3;
      rst = 1; tx_grant = 1;
      #1;
      model_reset();
      check("async_rst_rel",   32'(tx_rel),    32'd0);
      check("async_rst_rdata", tx_rdata,       32'd0);
      check("async_rst_size",  32'(last_size), 32'd0);
      check("async_rst_class", 32'(size_cls),  32'd0);
      check("async_rst_drop",  32'(drop_cnt),  32'd0);
      step(); step();
      rst = 0;
      n_rel = 0;
      for (int k = 0; k < 15; k++) begin step(); if (tx_rel) n_rel++; end
      check("no_rel_after_reset", 32'(n_rel), 32'd0);
      step();
      check("rel_at_next_tick", 32'(tx_rel), 32'd1);

      // Randomized traffic against the model
      for (int k = 0; k < 3000; k++) begin
         tx_en = ($urandom_range(0, 19) != 0);
         if ($urandom_range(0, 7) == 0) tx_grant = ~tx_grant;
         if ($urandom_range(0, 5) == 0) rx_grant = ~rx_grant;
         cfg_we    = ($urandom_range(0, 3) == 0);
         cfg_addr  = 5'($urandom_range(0, DEPTH - 1));
         cfg_wdata = $urandom;
         tx_addr   = 6'($urandom_range(0, 11));
         rx_we     = ($urandom_range(0, 2) == 0);
         rx_addr   = 9'($urandom_range(0, 3));
         rx_wdata  = {16'($urandom_range(0, 30)), 16'($urandom)};
         if (k == 1500) begin
            #3; rst = 1; #1; model_reset(); compare_all();
            step();
            rst = 0;
         end else begin
            step();
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
